// File: rtl/mole_scheduler_pkg.sv
// rtl/mole_scheduler_pkg.sv - shared types and constants for the mole scheduler
// Purpose : state encoding, hole count, LFSR feedback taps and a one-hot helper
//           shared by the scheduler top and its LFSR/index sub-module.
// Ports   : none (package).
package mole_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int N_HOLES = 10;

  // Fibonacci feedback taps 8,6,5,4 (bits 7,5,4,3): x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [N_HOLES-1:0] hole_onehot(input logic [3:0] idx);
    hole_onehot = N_HOLES'(1) << idx;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 8-bit LFSR with mod-10 hole index mapping
// Purpose : advances every clock regardless of game state and maps its low
//           nibble onto a hole index that never repeats the previous hole.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           i_hole_idx    - index of the current/last lit hole
//           o_index       - next hole index to light
module mole_lfsr
  import mole_scheduler_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_hole_idx,
  output logic [3:0] o_index
);

  logic [7:0] r_lfsr;
  logic [3:0] w_raw;
  logic [3:0] w_cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  // Fold 10..15 back onto 0..5; slightly biased toward low holes, which is fine for a game.
  assign w_raw  = r_lfsr[3:0];
  assign w_cand = (w_raw < 4'(N_HOLES)) ? w_raw : w_raw - 4'(N_HOLES);

  // Bump past the previous hole so the same hole is never lit twice in a row.
  assign o_index = (w_cand != i_hole_idx)        ? w_cand :
                   (w_cand == 4'(N_HOLES - 1))   ? 4'd0   : w_cand + 4'd1;

endmodule

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole hole scheduler
// Purpose : lights one random hole per spawn, times it out after LIFE_TICKS
//           speed ticks, and reports hits and per-hole misses.
// Ports   : clk, rst   - clock, asynchronous active-high reset
//           tick       - one-cycle speed pulse
//           enable     - game running; low forces IDLE
//           sw         - one-hot player switches, asynchronous to clk
//           out        - registered one-hot lit hole
//           fail       - registered one-cycle per-hole miss pulses
//           hit        - registered one-cycle correct-whack pulse
//           hole_idx   - index of the current or last lit hole
module mole_scheduler #(
  parameter int         N_HOLES    = mole_scheduler_pkg::N_HOLES,
  parameter int         LIFE_TICKS = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               enable,
  input  logic [N_HOLES-1:0] sw,
  output logic [N_HOLES-1:0] out,
  output logic [N_HOLES-1:0] fail,
  output logic               hit,
  output logic [3:0]         hole_idx
);

  import mole_scheduler_pkg::*;

  logic [N_HOLES-1:0] r_sync1;
  logic [N_HOLES-1:0] r_sync2;
  logic [N_HOLES-1:0] r_sync_q;
  logic [N_HOLES-1:0] w_whack;
  logic [N_HOLES-1:0] w_wrong;
  logic [N_HOLES-1:0] w_wrong_one;
  logic               w_correct;

  state_t             r_state;
  state_t             w_state;
  logic [N_HOLES-1:0] r_out;
  logic [N_HOLES-1:0] w_out;
  logic [N_HOLES-1:0] r_fail;
  logic [N_HOLES-1:0] w_fail;
  logic               r_hit;
  logic               w_hit;
  logic [3:0]         r_hole_idx;
  logic [3:0]         w_hole_idx;
  logic [3:0]         r_life;
  logic [3:0]         w_life;
  logic [3:0]         w_index;

  mole_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .i_hole_idx (r_hole_idx),
    .o_index    (w_index)
  );

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync_q <= '0;
    end else begin
      r_sync1  <= sw;
      r_sync2  <= r_sync1;
      r_sync_q <= r_sync2;
    end
  end

  assign w_whack   = r_sync2 & ~r_sync_q;
  assign w_correct = |(w_whack & r_out);
  assign w_wrong   = w_whack & ~r_out;
  // Keep only the lowest wrong whack so fail never carries two bits.
  assign w_wrong_one = w_wrong & (~w_wrong + N_HOLES'(1));

  always_comb begin
    w_state    = r_state;
    w_out      = r_out;
    w_fail     = '0;
    w_hit      = 1'b0;
    w_hole_idx = r_hole_idx;
    w_life     = r_life;
    if (!enable) begin
      w_state = ST_IDLE;
      w_out   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tick) begin
            w_hole_idx = w_index;
            w_out      = hole_onehot(w_index);
            w_life     = 4'(LIFE_TICKS);
            w_state    = ST_SHOW;
          end
        end
        ST_SHOW: begin
          w_fail = w_wrong_one;
          // A correct whack beats a coincident tick: no decrement, no expiry.
          if (w_correct) begin
            w_hit   = 1'b1;
            w_out   = '0;
            w_state = ST_GAP;
          end else if (tick) begin
            if (r_life == 4'd1) begin
              // Expiry miss takes the fail bus over any coincident wrong whack.
              w_fail  = hole_onehot(r_hole_idx);
              w_out   = '0;
              w_state = ST_GAP;
            end else begin
              w_life = r_life - 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            w_state = ST_IDLE;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_out   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_out      <= '0;
      r_fail     <= '0;
      r_hit      <= 1'b0;
      r_hole_idx <= 4'd0;
      r_life     <= 4'd0;
    end else begin
      r_state    <= w_state;
      r_out      <= w_out;
      r_fail     <= w_fail;
      r_hit      <= w_hit;
      r_hole_idx <= w_hole_idx;
      r_life     <= w_life;
    end
  end

  assign out      = r_out;
  assign fail     = r_fail;
  assign hit      = r_hit;
  assign hole_idx = r_hole_idx;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - self-checking bench for mole_scheduler
module tb_mole_scheduler;
  import mole_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] sw = '0;
  logic [9:0] out;
  logic [9:0] fail;
  logic       hit;
  logic [3:0] hole_idx;

  mole_scheduler #(
    .N_HOLES    (10),
    .LIFE_TICKS (3),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .enable   (enable),
    .sw       (sw),
    .out      (out),
    .fail     (fail),
    .hit      (hit),
    .hole_idx (hole_idx)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8 + x^6 + x^5 + x^4 + 1, shifting left.
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] m_last = 4'd0;

  typedef struct {
    string name;
    int    hole;
    int    off;
    bit    tk;
    bit    dual;
    bit    e_hit;
    bit    e_wrong;
    bit    e_lit;
    int    e_life;
  } vec_t;

  typedef struct packed {
    logic       h;
    logic [9:0] f;
    logic [9:0] o;
    logic [3:0] life;
  } exp_t;

  typedef struct packed {
    logic       tk;
    logic [3:0] cand;
  } pred_t;

  exp_t  sb[$];
  pred_t pq[$];
  vec_t  vt[8];

  function automatic logic [9:0] oh(input int i);
    logic [9:0] one = 10'd1;
    return one << i;
  endfunction

  function automatic logic [3:0] map_idx(input logic [7:0] l, input logic [3:0] last);
    int c = int'(l[3:0]);
    if (c >= 10) c = c - 10;
    if (c == int'(last)) c = (c + 1) % 10;
    return 4'(c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spawn_at(input int want, output logic [3:0] idx);
    int guard = 0;
    while (want >= 0 && int'(map_idx(m_lfsr, m_last)) != want && guard < 600) begin
      step();
      guard++;
    end
    check("spawn_wait_bound", 32'(guard < 600), 1);
    idx = map_idx(m_lfsr, m_last);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("spawn_out", out, oh(int'(idx)));
    check("spawn_idx", hole_idx, idx);
    check("spawn_state", dut.r_state, ST_SHOW);
    m_last = idx;
  endtask

  initial begin
    logic [3:0] idx;
    logic [3:0] idx2;
    int         n_ticks, cycles, n_spawn, n_hit, n_exp, press_cnt;
    logic [9:0] prev_out;
    pred_t      p;

    vt[0] = '{"correct_h4",      4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vt[1] = '{"wrong_p7_on_h2",  2, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[2] = '{"wrong_p7_on_h4",  4, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[3] = '{"correct_tick_h2", 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vt[4] = '{"wrong_tick_h6",   6, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vt[5] = '{"correct_h9",      9, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vt[6] = '{"wrong_p9_on_h0",  0, 9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vt[7] = '{"dual_h5_p8",      5, 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3};

    // Reset state
    rst = 1'b1;
    step(3);
    check("rst_out", out, 0);
    check("rst_fail", fail, 0);
    check("rst_hit", hit, 0);
    check("rst_idx", hole_idx, 0);
    check("rst_lfsr", dut.u_lfsr.r_lfsr, 8'hA5);
    check("rst_state", dut.r_state, ST_IDLE);
    rst = 1'b0;
    enable = 1'b1;
    m_last = 4'd0;

    // First spawn around cycle 10 after reset
    step(9);
    spawn_at(-1, idx);
    check("first_life", dut.r_life, 3);

    // Enable drop aborts the mole silently
    enable = 1'b0;
    step();
    check("abort_out", out, 0);
    check("abort_pulses", {hit, fail}, 0);
    check("abort_state", dut.r_state, ST_IDLE);
    enable = 1'b1;

    // Whack while idle is ignored
    sw = oh(3);
    step(3);
    check("idle_whack_fail", fail, 0);
    check("idle_whack_hit", hit, 0);
    sw = '0;
    step(3);

    // Expiry after three ticks, then one empty tick, then a different hole
    spawn_at(-1, idx);
    for (int t = 1; t <= 3; t++) begin
      step(7);
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (t < 3) begin
        check("exp_still_lit", out, oh(int'(idx)));
        check("exp_no_fail", fail, 0);
      end else begin
        check("exp_fail", fail, oh(int'(idx)));
        check("exp_out_clear", out, 0);
        check("exp_no_hit", hit, 0);
      end
    end
    step();
    check("exp_fail_single", fail, 0);
    step(6);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("gap_no_spawn", out, 0);
    check("gap_to_idle", dut.r_state, ST_IDLE);
    step(7);
    spawn_at(-1, idx2);
    check("respawn_differs", 32'(idx2 != idx), 1);

    // Asynchronous reset in the middle of SHOW
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", out, 0);
    check("rst_async_fail", fail, 0);
    check("rst_async_lfsr", dut.u_lfsr.r_lfsr, 8'hA5);
    step();
    rst = 1'b0;
    m_last = 4'd0;
    step(2);

    // Table-driven whack scenarios
    for (int i = 0; i < 8; i++) begin
      int   ph;
      exp_t e;
      spawn_at(vt[i].hole, idx);
      ph = (vt[i].hole + vt[i].off) % 10;
      sw = oh(ph) | (vt[i].dual ? oh(vt[i].hole) : 10'd0);
      sb.push_back('{h: vt[i].e_hit,
                     f: vt[i].e_wrong ? oh(ph) : 10'd0,
                     o: vt[i].e_lit ? oh(vt[i].hole) : 10'd0,
                     life: 4'(vt[i].e_life)});
      step(2);
      check({vt[i].name, "_early"}, {hit, fail}, 0);
      tick = vt[i].tk;
      step();
      tick = 1'b0;
      e = sb.pop_front();
      check({vt[i].name, "_hit"}, hit, e.h);
      check({vt[i].name, "_fail"}, fail, e.f);
      check({vt[i].name, "_out"}, out, e.o);
      check({vt[i].name, "_life"}, dut.r_life, e.life);
      step();
      check({vt[i].name, "_pulse_end"}, {hit, fail}, 0);
      sw = '0;
      enable = 1'b0;
      step();
      check({vt[i].name, "_abort_out"}, out, 0);
      check({vt[i].name, "_abort_pulse"}, {hit, fail}, 0);
      check({vt[i].name, "_abort_state"}, dut.r_state, ST_IDLE);
      enable = 1'b1;
      step(3);
    end

    // Random run: invariants plus spawn-index scoreboard
    n_ticks = 0; cycles = 0; n_spawn = 0; n_hit = 0; n_exp = 0; press_cnt = 0;
    prev_out = out;
    while (n_ticks < 10000 && cycles < 60000) begin
      tick = ($urandom_range(0, 2) == 0);
      if (tick) n_ticks++;
      if (press_cnt == 0 && $urandom_range(0, 5) == 0) begin
        sw = (out != 0 && $urandom_range(0, 2) != 0) ? out : oh(int'($urandom_range(0, 9)));
        press_cnt = 7;
      end else if (press_cnt > 0) begin
        press_cnt--;
        if (press_cnt == 3) sw = '0;
      end
      pq.push_back('{tk: tick, cand: map_idx(m_lfsr, m_last)});
      step();
      cycles++;
      p = pq.pop_front();
      check("rnd_out_onehot0", 32'($onehot0(out)), 1);
      check("rnd_fail_onehot0", 32'($onehot0(fail)), 1);
      if (prev_out == 0 && out != 0) begin
        n_spawn++;
        check("rnd_spawn_on_tick", p.tk, 1);
        check("rnd_spawn_idx", hole_idx, p.cand);
        check("rnd_spawn_out", out, oh(int'(p.cand)));
        check("rnd_no_repeat", 32'(hole_idx != m_last), 1);
        m_last = p.cand;
      end
      if (hit) n_hit++;
      if (fail != 0 && fail == prev_out && out == 0 && !hit) n_exp++;
      prev_out = out;
    end
    sw = '0;
    tick = 1'b0;
    check("rnd_tick_budget", n_ticks, 10000);
    check("rnd_balance", n_spawn, n_hit + n_exp + int'(out != 0));
    check("rnd_saw_hits", 32'(n_hit > 0), 1);
    check("rnd_saw_expiry", 32'(n_exp > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
